// File: rtl/lsu_pkg.sv
// Shared constants, state encoding and request-legality helper for the data-memory LSU.
package lsu_pkg;

    localparam int DATA_W = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RMW_RD,
        WR,
        RESP
    } lsu_state_e;

    // Stores have no unsigned variants, so BU/HU are only legal on loads.
    function automatic logic f3_legal(input logic [2:0] funct3, input logic we);
        logic ok;
        case (funct3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = !we;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane logic: extracts and extends load data from a memory word, and merges
// sub-word store data into a base word (little-endian byte lanes).
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]        funct3,
    input  logic [1:0]        offset,
    input  logic [DATA_W-1:0] base,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] load_data,
    output logic [DATA_W-1:0] store_data
);

    function automatic logic [DATA_W-1:0] ext_byte(input logic [7:0] b, input logic sgn);
        logic signed [7:0]        b_s;
        logic signed [DATA_W-1:0] b_ext;
        b_s   = b;
        b_ext = DATA_W'(b_s);
        if (sgn) return b_ext;
        return {{(DATA_W-8){1'b0}}, b};
    endfunction

    function automatic logic [DATA_W-1:0] ext_half(input logic [15:0] h, input logic sgn);
        logic signed [15:0]       h_s;
        logic signed [DATA_W-1:0] h_ext;
        h_s   = h;
        h_ext = DATA_W'(h_s);
        if (sgn) return h_ext;
        return {{(DATA_W-16){1'b0}}, h};
    endfunction

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    assign lane_byte = base[{offset, 3'b000} +: 8];
    assign lane_half = offset[1] ? base[31:16] : base[15:0];

    always_comb begin
        load_data = base;
        case (funct3)
            F3_B:    load_data = ext_byte(lane_byte, 1'b1);
            F3_BU:   load_data = ext_byte(lane_byte, 1'b0);
            F3_H:    load_data = ext_half(lane_half, 1'b1);
            F3_HU:   load_data = ext_half(lane_half, 1'b0);
            default: load_data = base;
        endcase
    end

    always_comb begin
        store_data = base;
        case (funct3)
            F3_B:    store_data[{offset, 3'b000} +: 8] = wdata[7:0];
            F3_H:    store_data[{offset[1], 4'b0000} +: 16] = wdata[15:0];
            F3_W:    store_data = wdata;
            default: store_data = base;
        endcase
    end

endmodule

// File: rtl/data_mem_lsu.sv
// Load/store unit driving a word-wide tri-state data memory; sub-word stores
// are done as read-modify-write since the memory only writes whole words.
module data_mem_lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH   = 16,
    parameter int SIM_MEM_SIZE = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [2:0]            req_funct3_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_W-1:0]     req_wdata_i,
    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic [DATA_W-1:0]     resp_rdata_o,
    output logic                  resp_err_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    inout  tri   [DATA_W-1:0]     mem_bus_io,
    output logic                  mem_re_o,
    output logic                  mem_we_o
);

    localparam int unsigned ADDR_LIMIT = SIM_MEM_SIZE * 4;

    lsu_state_e state_q, state_d;

    logic [ADDR_WIDTH-1:0] addr_p0;
    logic [2:0]            funct3_p0;
    logic [DATA_W-1:0]     wdata_p0;
    logic [DATA_W-1:0]     base_p1;
    logic [DATA_W-1:0]     rdata_q;
    logic                  err_q;

    logic                  accept;
    logic                  misaligned;
    logic                  req_err;
    logic [ADDR_WIDTH-1:0] word_addr;
    logic [DATA_W-1:0]     align_base;
    logic [DATA_W-1:0]     load_data;
    logic [DATA_W-1:0]     store_data;

    always_comb begin
        misaligned = 1'b0;
        case (req_funct3_i)
            F3_H, F3_HU: misaligned = req_addr_i[0];
            F3_W:        misaligned = |req_addr_i[1:0];
            default:     misaligned = 1'b0;
        endcase
    end

    assign req_err   = !f3_legal(req_funct3_i, req_we_i) || misaligned
                     || (32'(req_addr_i) >= ADDR_LIMIT);
    assign accept    = (state_q == IDLE) && req_valid_i;
    assign word_addr = {addr_p0[ADDR_WIDTH-1:2], 2'b00};

    // Loads extract straight from the bus; stores merge into the word captured in RMW_RD.
    assign align_base = (state_q == RD) ? mem_bus_io : base_p1;

    lsu_align u_align (
        .funct3     (funct3_p0),
        .offset     (addr_p0[1:0]),
        .base       (align_base),
        .wdata      (wdata_p0),
        .load_data  (load_data),
        .store_data (store_data)
    );

    assign mem_bus_io = (state_q == WR) ? store_data : 'z;

    always_comb begin
        state_d      = state_q;
        req_ready_o  = 1'b0;
        resp_valid_o = 1'b0;
        mem_re_o     = 1'b0;
        mem_we_o     = 1'b0;
        mem_addr_o   = '0;
        case (state_q)
            IDLE: begin
                req_ready_o = rst_n;
                if (req_valid_i) begin
                    if (req_err)                  state_d = RESP;
                    else if (!req_we_i)           state_d = RD;
                    else if (req_funct3_i == F3_W) state_d = WR;
                    else                          state_d = RMW_RD;
                end
            end
            RD: begin
                mem_re_o   = 1'b1;
                mem_addr_o = word_addr;
                state_d    = RESP;
            end
            RMW_RD: begin
                mem_re_o   = 1'b1;
                mem_addr_o = word_addr;
                state_d    = WR;
            end
            WR: begin
                mem_we_o   = 1'b1;
                mem_addr_o = word_addr;
                state_d    = RESP;
            end
            RESP: begin
                resp_valid_o = 1'b1;
                if (resp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                rdata_q <= '0;
                err_q   <= req_err;
            end else if (state_q == RD) begin
                rdata_q <= load_data;
            end
        end
    end

    // Request capture and merge base: data only, no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_p0   <= req_addr_i;
            funct3_p0 <= req_funct3_i;
            wdata_p0  <= req_wdata_i;
        end
        if (state_q == RMW_RD) begin
            base_p1 <= mem_bus_io;
        end
    end

    assign resp_rdata_o = rdata_q;
    assign resp_err_o   = err_q;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Randomised self-checking bench for data_mem_lsu against a word-array reference model.
module tb_data_mem_lsu;
    import lsu_pkg::*;

    localparam int ADDR_WIDTH   = 16;
    localparam int SIM_MEM_SIZE = 1024;
    localparam logic [31:0] BUS_IDLE = 32'hFFFF_FFFF;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  req_valid = 1'b0;
    logic                  req_ready;
    logic                  req_we = 1'b0;
    logic [2:0]            req_funct3 = 3'b000;
    logic [ADDR_WIDTH-1:0] req_addr = '0;
    logic [31:0]           req_wdata = '0;
    logic                  resp_valid;
    logic                  resp_ready = 1'b1;
    logic [31:0]           resp_rdata;
    logic                  resp_err;
    logic [ADDR_WIDTH-1:0] mem_addr;
    tri   [31:0]           mem_bus;
    logic                  mem_re;
    logic                  mem_we;

    logic [31:0] mem     [SIM_MEM_SIZE];
    logic [31:0] ref_mem [SIM_MEM_SIZE];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    data_mem_lsu #(.ADDR_WIDTH(ADDR_WIDTH), .SIM_MEM_SIZE(SIM_MEM_SIZE)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_we_i     (req_we),
        .req_funct3_i (req_funct3),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .resp_rdata_o (resp_rdata),
        .resp_err_o   (resp_err),
        .mem_addr_o   (mem_addr),
        .mem_bus_io   (mem_bus),
        .mem_re_o     (mem_re),
        .mem_we_o     (mem_we)
    );

    // Memory: combinational read onto the bus, write at posedge; weak pull-up marks an idle bus.
    pullup (mem_bus);
    assign mem_bus = mem_re ? mem[mem_addr[11:2]] : 32'bz;
    always @(posedge clk) if (mem_we) mem[mem_addr[11:2]] <= mem_bus;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference: access rules applied to a plain word array.
    function automatic void model(input logic we, input logic [2:0] f3, input logic [15:0] a,
                                  input logic [31:0] wd, output logic err, output logic [31:0] rdata,
                                  output int lat, output int n_re, output int n_we,
                                  output logic [31:0] wr_word);
        int size, idx, sh;
        logic [31:0] w, mask;
        err = 1'b0; rdata = '0; lat = 1; n_re = 0; n_we = 0; wr_word = '0;
        case (f3)
            3'd0, 3'd4: size = 1;
            3'd1, 3'd5: size = 2;
            3'd2:       size = 4;
            default: begin size = 1; err = 1'b1; end
        endcase
        if (we && f3 >= 3'd4) err = 1'b1;
        if ((int'(a) % size) != 0) err = 1'b1;
        if (int'(a) >= SIM_MEM_SIZE * 4) err = 1'b1;
        if (err) return;
        idx  = int'(a) / 4;
        sh   = (int'(a) % 4) * 8;
        w    = ref_mem[idx];
        mask = 32'((64'd1 << (size * 8)) - 64'd1);
        if (!we) begin
            rdata = (w >> sh) & mask;
            if (f3 < 3'd4 && size < 4 && rdata[size*8-1]) rdata = rdata | ~mask;
            lat = 2; n_re = 1;
        end else begin
            wr_word = (w & ~(mask << sh)) | ((wd << sh) & (mask << sh));
            ref_mem[idx] = wr_word;
            lat  = (size == 4) ? 2 : 3;
            n_re = (size == 4) ? 0 : 1;
            n_we = 1;
        end
    endfunction

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [15:0] a,
                          input logic [31:0] wd, input int stall);
        logic e_err;
        logic [31:0] e_rd, e_wr;
        int e_lat, e_re, e_we, lat, nre, nwe;
        model(we, f3, a, wd, e_err, e_rd, e_lat, e_re, e_we, e_wr);
        check("req_ready in idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        resp_ready = (stall == 0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1; nre = 0; nwe = 0;
        while (!resp_valid && lat < 8) begin
            check("re/we exclusive", 32'(mem_re & mem_we), 32'd0);
            if (mem_re) begin
                nre++;
                check("read addr", 32'(mem_addr), 32'({a[15:2], 2'b00}));
            end
            if (mem_we) begin
                nwe++;
                check("write addr", 32'(mem_addr), 32'({a[15:2], 2'b00}));
                check("write bus", mem_bus, e_wr);
            end
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 32'(lat), 32'(e_lat));
        check("resp_err", 32'(resp_err), 32'(e_err));
        check("resp_rdata", resp_rdata, e_rd);
        check("re cycles", 32'(nre), 32'(e_re));
        check("we cycles", 32'(nwe), 32'(e_we));
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            check("stall resp_valid", 32'(resp_valid), 32'd1);
            check("stall rdata", resp_rdata, e_rd);
            check("stall req_ready", 32'(req_ready), 32'd0);
            check("stall re/we", 32'({mem_re, mem_we}), 32'd0);
            check("stall bus idle", mem_bus, BUS_IDLE);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        check("resp_valid after handshake", 32'(resp_valid), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < SIM_MEM_SIZE; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[4] = 32'h8899_AABB;
        ref_mem[4] = 32'h8899_AABB;

        #12;
        check("reset req_ready", 32'(req_ready), 32'd0);
        check("reset resp_valid", 32'(resp_valid), 32'd0);
        check("reset resp_err", 32'(resp_err), 32'd0);
        check("reset resp_rdata", resp_rdata, 32'd0);
        check("reset mem_addr", 32'(mem_addr), 32'd0);
        check("reset re/we", 32'({mem_re, mem_we}), 32'd0);
        check("reset bus idle", mem_bus, BUS_IDLE);
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_req(1'b0, F3_B,  16'h0013, 32'h0, 0);
        do_req(1'b0, F3_BU, 16'h0013, 32'h0, 0);
        do_req(1'b0, F3_HU, 16'h0010, 32'h0, 0);
        do_req(1'b0, F3_H,  16'h0012, 32'h0, 0);
        do_req(1'b1, F3_H,  16'h0012, 32'hDEAD_1234, 0);
        do_req(1'b0, F3_W,  16'h0010, 32'h0, 0);
        do_req(1'b1, F3_W,  16'h0020, 32'hCAFE_F00D, 0);
        do_req(1'b0, F3_W,  16'h0020, 32'h0, 0);
        do_req(1'b0, F3_W,  16'h0012, 32'h0, 0);
        do_req(1'b1, F3_H,  16'h0011, 32'h1111_2222, 0);
        do_req(1'b0, 3'b011, 16'h0010, 32'h0, 0);
        do_req(1'b1, F3_BU, 16'h0010, 32'h0000_00AA, 0);
        do_req(1'b0, F3_W,  16'(SIM_MEM_SIZE * 4), 32'h0, 0);
        do_req(1'b0, F3_W,  16'(SIM_MEM_SIZE * 4 - 4), 32'h0, 0);
        do_req(1'b0, F3_W,  16'h0010, 32'h0, 3);

        // Reset while the sub-word store is reading its merge base.
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_B; req_addr = 16'h0010; req_wdata = 32'h55;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("rmw read active", 32'(mem_re), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async reset re/we", 32'({mem_re, mem_we}), 32'd0);
        check("async reset bus idle", mem_bus, BUS_IDLE);
        check("async reset req_ready", 32'(req_ready), 32'd0);
        check("async reset mem_addr", 32'(mem_addr), 32'd0);
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_req(1'b0, F3_W, 16'h0010, 32'h0, 0);

        for (int t = 0; t < 200; t++) begin
            logic [15:0] a;
            case ($urandom_range(0, 9))
                0:       a = 16'($urandom_range(SIM_MEM_SIZE * 4 - 4, SIM_MEM_SIZE * 4 + 3));
                1:       a = 16'($urandom);
                default: a = 16'($urandom_range(0, 63));
            endcase
            do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
                   int'($urandom_range(0, 3) == 0 ? $urandom_range(1, 2) : 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/data_mem_lsu.md
Name: data_mem_lsu

Overview:
- Load/store initiator that drives the shared word-wide data memory over its tri-state bus, using address, read-enable and write-enable.
- Accepts RV32 load/store requests from the pipeline MEM stage over a valid/ready handshake.
- Performs byte/half/word accesses. Sub-word stores use read-modify-write because the memory only writes whole words.
- Returns sign- or zero-extended load data plus an error flag on a valid/ready response channel.

Parameters:
- ADDR_WIDTH, 16, byte-address width of request and memory address.
- SIM_MEM_SIZE, 1024, number of memory words; addresses at or beyond SIM_MEM_SIZE*4 are out of range.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- req_valid_i  input  1  request valid
- req_ready_o  output  1  LSU can accept a request
- req_we_i  input  1  1=store, 0=load
- req_funct3_i  input  3  RV32 funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr_i  input  ADDR_WIDTH  byte address
- req_wdata_i  input  32  store data, LSB-aligned
- resp_valid_o  output  1  response valid
- resp_ready_i  input  1  response accepted
- resp_rdata_o  output  32  extended load data; 0 for stores and errors
- resp_err_o  output  1  misaligned, out-of-range or illegal funct3
- mem_addr_o  output  ADDR_WIDTH  word-aligned byte address (bits [1:0] = 0)
- mem_bus_io  inout  32 (tri)  shared data bus
- mem_re_o  output  1  memory drives the bus combinationally while high
- mem_we_o  output  1  memory writes the bus value at posedge while high

Behaviour:
- Reset (async, while rst_n=0):
  - State goes to IDLE.
  - mem_re_o=0, mem_we_o=0, bus released to 'z.
  - resp_valid_o=0, resp_err_o=0, resp_rdata_o=0, mem_addr_o=0.
  - req_ready_o=0 while in reset, 1 once in IDLE.
  - A reset mid-RMW abandons the access. No write is issued.
- States: IDLE, RD, RMW_RD, WR, RESP.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i, capture addr, funct3, we and wdata into registers.
  - Check for errors:
    - misaligned: H/HU with addr[0]!=0, W with addr[1:0]!=0;
    - funct3 not in {000,001,010,100,101};
    - store with funct3 BU/HU;
    - addr out of range.
  - Error → RESP with err=1 and no bus activity.
  - Load → RD. Word store → WR. Byte/half store → RMW_RD.
- RD / RMW_RD:
  - mem_re_o=1 and mem_addr_o={addr[AW-1:2],2'b00}. LSU never drives the bus.
  - Bus value is captured at posedge.
  - RD → RESP, with extracted and extended data.
  - RMW_RD → WR, with the captured word kept as the merge base.
- WR:
  - mem_we_o=1 and mem_re_o=0.
  - LSU drives the bus with the store word:
    - W: wdata;
    - B: base with byte lane addr[1:0] replaced by wdata[7:0];
    - H: base with half lane addr[1] replaced by wdata[15:0].
  - Little-endian lanes: byte n = bits [8n+7:8n].
  - → RESP.
- RESP:
  - resp_valid_o=1; outputs stay stable until resp_ready_i.
  - On handshake → IDLE. The next request is accepted only in IDLE, so there is no overlap.
- Bus rules:
  - LSU drives mem_bus_io only in WR; otherwise 'z.
  - mem_re_o and mem_we_o are never high in the same cycle.
- Latency from accept to resp_valid_o:
  - load 2 cycles;
  - word store 2;
  - sub-word store 3;
  - error 1.
- Throughput: no back-to-back acceptance. Minimum request spacing = latency + 1.

Decomposition:
- lsu_pkg holds:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - lsu_state_e enum;
  - width constants.
- One combinational sub-module, lsu_align: load extract/extend and store lane merge, given funct3, addr[1:0], base and wdata.
- The FSM, registers and tri-state driver stay in data_mem_lsu.

Test Plan:
- Preload mem word 0x10=0x8899AABB; lb 0x13 → rdata 0xFFFFFF88 at 2 cycles; lbu 0x13 → 0x00000088; lhu 0x10 → 0x0000AABB; lh 0x12 → 0xFFFF8899; err=0 throughout.
- sh 0x12 with wdata 0xDEAD1234 → re for one cycle, then we for one cycle with bus 0x1234AABB; subsequent lw 0x10 → 0x1234AABB.
- sw 0x20 with 0xCAFEF00D → no re cycle, one we cycle at addr 0x20, response at 2 cycles; lw 0x20 → 0xCAFEF00D.
- lw 0x12, sh 0x11, funct3 011, sbu, and addr = SIM_MEM_SIZE*4 → resp_err_o=1 after 1 cycle, rdata 0, re/we never asserted.
- Hold resp_ready_i=0 for 3 cycles after a load → resp_valid/rdata stable, req_ready_o=0, bus 'z, no re/we.
- Assert rst_n=0 during RMW_RD of sb 0x10 → re/we drop immediately with no clock, bus 'z; after release, lw 0x10 shows the original word unchanged.
